fluid_path_arbiter: RTL and testbench
=====================================

Name: fluid_path_arbiter

Overview:
- Shares one pump/mixer flow path between N_REQ chamber stages (Mix, Filter, Heat, Detect, ...) that request fluid transfers.
- Round-robin arbiter plus a per-transfer timing FSM: valves settle, the pump runs for a requester-supplied dwell, then the valves close and settle.
- Sits between the assay scheduler (which drives req/dwell) and the valve and pump drivers of the chamber/mixer netlist.

Parameters:
- N_REQ, 4, number of requesting stages (≥2).
- CNT_W, 16, width of each dwell count and of the internal timer.
- SETTLE, 4, cycles spent in OPEN and in CLOSE (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N_REQ  per-stage transfer request, level-sensitive.
- dwell  input  N_REQ*CNT_W  per-stage pump cycles; stage i occupies bits [i*CNT_W +: CNT_W].
- abort  input  1  terminate the current transfer early.
- grant  output  N_REQ  one-hot; the stage that owns the path.
- valve_open  output  N_REQ  valve drive for the granted stage.
- pump_on  output  1  shared pump drive.
- done  output  N_REQ  one-cycle pulse to the stage whose transfer finished.
- aborted  output  1  one-cycle pulse, coincident with done, when the transfer ended by abort.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst_n sampled low at a clock edge.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The round-robin pointer is set so stage 0 has highest priority.
  - Reset mid-transfer drops the pump and valves at that same edge, with no done pulse.
- All outputs are registered.
- States: IDLE, OPEN, PUMP, CLOSE, DONE.
- IDLE:
  - If any req bit is high, pick the first requester at or after ptr, searching upward with wrap-around.
  - Latch its index and dwell, and go to OPEN.
  - At the next edge set grant, and set ptr = winner+1 mod N_REQ.
  - Latency is req high at edge t -> grant high after edge t+1.
- OPEN:
  - valve_open[winner]=1, pump_on=0.
  - Lasts exactly SETTLE cycles.
  - Then go to PUMP, or to CLOSE if the latched dwell==0.
- PUMP:
  - valve_open[winner]=1, pump_on=1.
  - Lasts exactly the latched dwell cycles; the counter counts down to 1.
  - Then go to CLOSE.
- CLOSE:
  - valve_open=0, pump_on=0, grant still held.
  - Lasts exactly SETTLE cycles, then go to DONE.
- DONE:
  - Lasts one cycle: done[winner]=1, grant cleared at the end.
  - Return to IDLE; re-arbitration happens in IDLE, so there is at least one idle cycle between grants.
- Changes to req or dwell after the grant are ignored. Dropping req mid-transfer does not shorten the transfer.
- A stage holding req high through DONE is re-granted only if no other requester wins under round-robin.
- abort:
  - Ignored in IDLE, CLOSE and DONE.
  - In OPEN or PUMP, the next state is CLOSE: pump_on and valve_open are 0 from the next cycle.
  - The full SETTLE close then runs, and aborted pulses together with done.
- Simultaneous abort and the natural end of OPEN or PUMP: the abort takes effect, so aborted=1.
- Invariants:
  - grant, valve_open and done are each one-hot or zero.
  - valve_open ⊆ grant.
  - pump_on implies valve_open≠0.
- Timer width is CNT_W. dwell=2^CNT_W−1 runs the full count with no overflow.

Test Plan:
- Single request, N_REQ=4, SETTLE=4, req=0001, dwell0=10:
  - grant=0001 one cycle after req.
  - valve_open high 14 cycles.
  - pump_on high 10 cycles, starting 4 cycles after grant.
  - 4 CLOSE cycles, then a done=0001 pulse.
  - busy high 19 cycles in total.
- Round-robin fairness with req=1111 held, all dwell=2:
  - Grant order 0,1,2,3,0.
  - Each done precedes the next grant by at least 1 idle cycle.
- dwell=0 on stage 2:
  - pump_on never rises.
  - OPEN 4 cycles, then CLOSE 4 cycles, then done=0100.
  - aborted=0.
- Abort in PUMP, dwell=100, abort pulsed on the 5th PUMP cycle:
  - pump_on=0 the next cycle.
  - 4 CLOSE cycles.
  - done and aborted pulse together; the next requester is then granted normally.
- Reset mid-PUMP: rst_n low for one edge:
  - All outputs 0 immediately after that edge, with no done pulse.
  - After release with req=1010, stage 1 is granted first because ptr was reset.
- Req withdrawn after grant: req0 drops in OPEN:
  - The transfer still completes its full dwell and pulses done=0001.

Source files
------------

// File: rtl/fluid_path_arbiter.sv
// fluid_path_arbiter: round-robin owner of a shared pump/valve path with a settle/pump/settle transfer FSM
module fluid_path_arbiter #(
    parameter int N_REQ  = 4,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dwell,
    input  logic                   abort,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       valve_open,
    output logic                   pump_on,
    output logic [N_REQ-1:0]       done,
    output logic                   aborted,
    output logic                   busy
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic [2:0] {IDLE, OPEN, PUMP, CLOSE, DONE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, win, p;
    logic [CNT_W-1:0] cnt_q, cnt_d, dw_q, dw_d, dw_sel;
    logic ab_q, ab_d, found;
    logic [N_REQ-1:0] oh, grant_q, grant_d, valve_q, valve_d, done_q, done_d;
    logic pump_q, pump_d, aborted_q, aborted_d, busy_q, busy_d;
    // lowest k wins, so the search starts at ptr and wraps upward
    always_comb begin
        win = '0;
        found = 1'b0;
        p = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            p = IW'((int'(ptr_q) + k) % N_REQ);
            if (req[p]) begin
                found = 1'b1;
                win = p;
            end
        end
    end
    always_comb begin
        dw_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == IW'(i)) dw_sel = dwell[i*CNT_W +: CNT_W];
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        dw_d = dw_q;
        ab_d = ab_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = OPEN;
                idx_d = win;
                dw_d = dw_sel;
                cnt_d = CNT_W'(SETTLE);
                ptr_d = (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
                ab_d = 1'b0;
            end
            OPEN, PUMP: if (abort) begin
                state_d = CLOSE;
                cnt_d = CNT_W'(SETTLE);
                ab_d = 1'b1;
            end else if (cnt_q != CNT_W'(1)) begin
                cnt_d = cnt_q - 1'b1;
            end else if (state_q == OPEN && dw_q != '0) begin
                state_d = PUMP;
                cnt_d = dw_q;
            end else begin
                state_d = CLOSE;
                cnt_d = CNT_W'(SETTLE);
            end
            CLOSE: if (cnt_q == CNT_W'(1)) state_d = DONE; else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        // outputs decode the next state so they line up with the state register
        oh = {{(N_REQ-1){1'b0}}, 1'b1} << idx_d;
        grant_d = (state_d != IDLE) ? oh : '0;
        valve_d = (state_d == OPEN || state_d == PUMP) ? oh : '0;
        pump_d = state_d == PUMP;
        done_d = (state_d == DONE) ? oh : '0;
        aborted_d = state_d == DONE && ab_d;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            dw_q <= '0;
            ab_q <= 1'b0;
            grant_q <= '0;
            valve_q <= '0;
            pump_q <= 1'b0;
            done_q <= '0;
            aborted_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            dw_q <= dw_d;
            ab_q <= ab_d;
            grant_q <= grant_d;
            valve_q <= valve_d;
            pump_q <= pump_d;
            done_q <= done_d;
            aborted_q <= aborted_d;
            busy_q <= busy_d;
        end
    end
    assign grant = grant_q;
    assign valve_open = valve_q;
    assign pump_on = pump_q;
    assign done = done_q;
    assign aborted = aborted_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_fluid_path_arbiter.sv
// tb_fluid_path_arbiter: directed-vector bench for fluid_path_arbiter
module tb_fluid_path_arbiter;
    localparam int N = 4, W = 16, S = 4;
    logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] dwell = '0;
    logic [N-1:0] grant, valve_open, done;
    logic pump_on, aborted, busy;
    int n_chk = 0, n_err = 0;
    int nb, nv, np, ps, n;
    logic [N-1:0] dn;
    logic ab;
    int order[5];
    int ng, last_done, inv_bad, gap_bad;
    logic [N-1:0] prev;

    always #5 clk = ~clk;

    fluid_path_arbiter #(.N_REQ(N), .CNT_W(W), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dwell(dwell), .abort(abort),
        .grant(grant), .valve_open(valve_open), .pump_on(pump_on),
        .done(done), .aborted(aborted), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dwell(input int i, input int v);
        dwell[i*W +: W] = W'(v);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_valve"}, 32'(valve_open), 0);
        check({tag, "_pump"}, 32'(pump_on), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_aborted"}, 32'(aborted), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // called on the first granted cycle; walks the transfer until busy drops
    task automatic measure();
        nb = 0; nv = 0; np = 0; ps = -1; dn = '0; ab = 1'b0;
        for (int i = 0; i < 1000 && busy; i++) begin
            if (valve_open != '0) nv++;
            if (pump_on) begin
                if (ps < 0) ps = i;
                np++;
            end
            if (done != '0) begin
                dn = done;
                ab = aborted;
            end
            nb++;
            step();
        end
    endtask

    task automatic count_close();
        n = 0;
        while (done == '0 && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        // single request, dropped during OPEN
        set_dwell(0, 10);
        req = 4'b0001;
        step();
        check("t1_grant", 32'(grant), 1);
        req = '0;
        measure();
        check("t1_busy_cycles", nb, 19);
        check("t1_valve_cycles", nv, 14);
        check("t1_pump_cycles", np, 10);
        check("t1_pump_start", ps, 4);
        check("t1_done", 32'(dn), 1);
        check("t1_aborted", 32'(ab), 0);

        // round robin, fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < N; i++) set_dwell(i, 2);
        req = 4'b1111;
        ng = 0; last_done = -100; inv_bad = 0; gap_bad = 0; prev = '0;
        for (int c = 0; c < 400 && !(ng == 5 && !busy); c++) begin
            if (grant != '0 && prev == '0) begin
                if (ng < 5) order[ng] = $clog2(grant);
                if (c - last_done < 2) gap_bad++;
                ng++;
                if (ng == 5) req = '0;
            end
            if (done != '0) last_done = c;
            if ($countones(grant) > 1 || $countones(valve_open) > 1 || $countones(done) > 1 ||
                (valve_open & ~grant) != '0 || (pump_on && valve_open == '0)) inv_bad++;
            prev = grant;
            step();
        end
        check("rr_count", ng, 5);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), order[i], i % N);
        check("rr_idle_gap", gap_bad, 0);
        check("rr_invariants", inv_bad, 0);

        // zero dwell on stage 2
        set_dwell(2, 0);
        req = 4'b0100;
        step();
        check("t3_grant", 32'(grant), 4);
        req = '0;
        measure();
        check("t3_busy_cycles", nb, 9);
        check("t3_valve_cycles", nv, 4);
        check("t3_pump_cycles", np, 0);
        check("t3_done", 32'(dn), 4);
        check("t3_aborted", 32'(ab), 0);

        // abort on the 5th PUMP cycle, stage 0 waiting
        set_dwell(3, 100);
        set_dwell(0, 3);
        req = 4'b1001;
        step();
        check("t4_grant", 32'(grant), 8);
        repeat (4) step();
        check("t4_pump_start", 32'(pump_on), 1);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_pump_off", 32'(pump_on), 0);
        check("t4_valve_off", 32'(valve_open), 0);
        check("t4_grant_held", 32'(grant), 8);
        count_close();
        check("t4_close_cycles", n, 4);
        check("t4_done", 32'(done), 8);
        check("t4_aborted", 32'(aborted), 1);
        req = 4'b0001;
        step();
        check("t4_idle_grant", 32'(grant), 0);
        check("t4_idle_busy", 32'(busy), 0);
        step();
        check("t4_next_grant", 32'(grant), 1);
        req = '0;
        measure();
        check("t4_next_busy", nb, 12);
        check("t4_next_done", 32'(dn), 1);
        check("t4_next_aborted", 32'(ab), 0);

        // reset in the middle of PUMP
        set_dwell(3, 100);
        set_dwell(1, 5);
        req = 4'b1000;
        step();
        check("t5_grant", 32'(grant), 8);
        repeat (6) step();
        check("t5_pumping", 32'(pump_on), 1);
        rst_n = 1'b0;
        req = 4'b1010;
        step();
        check_idle("t5_midrst");
        rst_n = 1'b1;
        step();
        check("t5_ptr_reset", 32'(grant), 2);
        req = '0;
        measure();
        check("t5_busy_cycles", nb, 14);
        check("t5_done", 32'(dn), 2);

        // abort coinciding with the last OPEN cycle
        set_dwell(2, 5);
        req = 4'b0100;
        step();
        check("t6_grant", 32'(grant), 4);
        req = '0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_pump", 32'(pump_on), 0);
        check("t6_valve", 32'(valve_open), 0);
        count_close();
        check("t6_close_cycles", n, 4);
        check("t6_done", 32'(done), 4);
        check("t6_aborted", 32'(aborted), 1);

        // abort with nothing in flight does nothing
        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        check_idle("t7_idle_abort");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
